rr_input_mux: RTL and testbench

Parametrised, registered N-channel, WIDTH-bit input multiplexer with per-channel valid/ready handshakes and two selection modes: manual select and round-robin arbitration. It generalises the 4-input, 4-bit combinational ALU operand mux. It sits between the operand sources and the ALU input stage. It provides one-cycle registered output, back-pressure, and fair sharing when several sources are pending.

---
 rtl/rr_input_mux.sv | 111 +++++++++++
 tb/tb_rr_input_mux.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_input_mux.sv
// rr_input_mux: registered N-channel operand mux feeding the ALU,
// with manual select or round-robin arbitration and valid/ready flow.
module rr_input_mux #(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] i,
  input  logic [N-1:0]       i_valid,
  output logic [N-1:0]       i_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    s,
  output logic [WIDTH-1:0]   y,
  output logic [SELW-1:0]    y_sel,
  output logic               y_valid,
  input  logic               y_ready
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [WIDTH-1:0] ch [N];
  logic             man_hit;
  logic             rr_hit;
  logic [SELW-1:0]  rr_gnt;
  logic [SELW-1:0]  idx;
  logic             hit;
  logic [SELW-1:0]  gnt;
  logic             load;
  logic             xfer;

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch[k] = i[k*WIDTH +: WIDTH];
  end

  // Manual grant: s must name an existing channel that is pending
  assign man_hit = (int'(s) < N) && i_valid[s];

  // Round-robin search starting just after the last granted channel
  always_comb begin
    rr_hit = 1'b0;
    rr_gnt = '0;
    idx    = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = (idx == LAST) ? '0 : idx + SELW'(1);
      if (!rr_hit && i_valid[idx]) begin
        rr_hit = 1'b1;
        rr_gnt = idx;
      end
    end
  end

  assign hit  = mode ? rr_hit : man_hit;
  assign gnt  = mode ? rr_gnt : s;
  assign load = (state_q == EMPTY) || y_ready;
  assign xfer = load && hit;

  // State register: output word, its source index and the rr pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      y_q     <= '0;
      sel_q   <= '0;
      ptr_q   <= LAST;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: fill on grant, empty on drain without a replacement
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      EMPTY: if (hit) state_d = FULL;
      FULL:  if (y_ready && !hit) state_d = EMPTY;
    endcase
    if (xfer) begin
      y_d   = ch[gnt];
      sel_d = gnt;
      if (mode) ptr_d = gnt;
    end
  end

  // Outputs: one-hot ready toward the granted source only
  always_comb begin
    i_ready = '0;
    if (xfer && !rst) i_ready[gnt] = 1'b1;
  end

  assign y       = y_q;
  assign y_sel   = sel_q;
  assign y_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_input_mux.sv
// tb_rr_input_mux: randomized scoreboard bench for rr_input_mux,
// plus a small N=3 instance for out-of-range manual select.
module tb_rr_input_mux;

  localparam int W = 4;
  localparam int N = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   sel;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [W-1:0]   dat [N];
  logic [N*W-1:0] i;
  logic [N-1:0]   i_valid;
  logic [N-1:0]   i_ready;
  logic           mode;
  logic [1:0]     s;
  logic [W-1:0]   y;
  logic [1:0]     y_sel;
  logic           y_valid;
  logic           y_ready;

  logic [11:0]    i3;
  logic [2:0]     v3;
  logic [2:0]     ir3;
  logic [1:0]     s3;
  logic [3:0]     y3;
  logic [1:0]     ysel3;
  logic           yv3;
  logic           mode3;
  logic           yr3;

  int   n_chk;
  int   n_fail;
  bit   fixdata;
  exp_t exp_q [$];

  bit         m_full;
  int         m_ptr;
  bit         m_armed;
  bit         m_ld;
  bit         m_hit;
  int         m_g;
  logic [3:0] m_eir;

  bit         p_rst;
  bit         p_ld;
  bit         armed;
  logic [3:0] l_y;
  logic [1:0] l_sel;
  exp_t       e;

  assign i = {dat[3], dat[2], dat[1], dat[0]};

  rr_input_mux #(.WIDTH(W), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .mode    (mode),
    .s       (s),
    .y       (y),
    .y_sel   (y_sel),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  rr_input_mux #(.WIDTH(4), .N(3)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .i       (i3),
    .i_valid (v3),
    .i_ready (ir3),
    .mode    (mode3),
    .s       (s3),
    .y       (y3),
    .y_sel   (ysel3),
    .y_valid (yv3),
    .y_ready (yr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic m, input logic [1:0] sv,
                     input logic [3:0] v, input logic yr);
    @(negedge clk);
    rst     = r;
    mode    = m;
    s       = sv;
    i_valid = v;
    y_ready = yr;
    if (!fixdata)
      for (int k = 0; k < N; k++) dat[k] = 4'($urandom_range(15));
  endtask

  // Reference model: decides each transfer from the arbitration rules
  always begin
    @(negedge clk);
    #1;
    m_eir = '0;
    if (rst) begin
      m_full  = 1'b0;
      m_ptr   = N - 1;
      m_armed = 1'b1;
    end else begin
      m_ld  = !m_full || y_ready;
      m_hit = 1'b0;
      m_g   = 0;
      if (!mode) begin
        if (int'(s) < N && ((int'(i_valid) >> int'(s)) & 1) != 0) begin
          m_hit = 1'b1;
          m_g   = int'(s);
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (!m_hit && ((int'(i_valid) >> ((m_ptr + k) % N)) & 1) != 0) begin
            m_hit = 1'b1;
            m_g   = (m_ptr + k) % N;
          end
        end
      end
      if (m_ld && m_hit) m_eir = 4'(1 << m_g);
      if (m_ld) begin
        if (m_hit) begin
          exp_q.push_back(exp_t'{d: dat[2'(m_g)], sel: 2'(m_g)});
          m_full = 1'b1;
          if (mode) m_ptr = m_g;
        end else begin
          m_full = 1'b0;
        end
      end
    end
    if (m_armed) chk("i_ready", 32'(i_ready), 32'(m_eir));
  end

  // Monitor: pops the scoreboard whenever a new word is presented
  always begin
    @(negedge clk);
    #2;
    p_rst = rst;
    p_ld  = !y_valid || y_ready;
    @(posedge clk);
    #1;
    if (p_rst) begin
      chk("rst_y_valid", 32'(y_valid), 32'(0));
      chk("rst_y", 32'(y), 32'(0));
      chk("rst_y_sel", 32'(y_sel), 32'(0));
      l_y   = '0;
      l_sel = '0;
      armed = 1'b1;
      exp_q.delete();
    end else if (armed) begin
      chk("y_valid", 32'(y_valid), 32'(m_full));
      if (p_ld && y_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got y=%0h sel=%0d expected none",
                   y, y_sel);
        end else begin
          e = exp_q.pop_front();
          chk("y", 32'(y), 32'(e.d));
          chk("y_sel", 32'(y_sel), 32'(e.sel));
        end
        l_y   = y;
        l_sel = y_sel;
      end else begin
        if (exp_q.size() != 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL missing_word: got none expected sel=%0d",
                   exp_q[0].sel);
          exp_q.delete();
        end
        chk("y_hold", 32'(y), 32'(l_y));
        chk("y_sel_hold", 32'(y_sel), 32'(l_sel));
      end
    end
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    fixdata = 1'b0;
    armed   = 1'b0;
    m_armed = 1'b0;
    m_full  = 1'b0;
    m_ptr   = N - 1;
    rst     = 1'b1;
    mode    = 1'b1;
    s       = '0;
    i_valid = 4'hF;
    y_ready = 1'b1;
    for (int k = 0; k < N; k++) dat[k] = '0;
    i3      = 12'h963;
    v3      = '0;
    s3      = '0;
    mode3   = 1'b0;
    yr3     = 1'b1;

    repeat (2) cyc(1'b1, 1'b1, 2'd0, 4'hF, 1'b1);
    cyc(1'b0, 1'b1, 2'd0, 4'hF, 1'b1);
    #1 chk("first_rr_grant", 32'(i_ready), 32'h1);

    fixdata = 1'b1;
    dat[0] = 4'hA;
    dat[1] = 4'hB;
    dat[2] = 4'hC;
    dat[3] = 4'hD;
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 2'(k), 4'hF, 1'b1);
    fixdata = 1'b0;

    repeat (8) cyc(1'b0, 1'b1, 2'd0, 4'hF, 1'b1);
    repeat (4) cyc(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1);

    cyc(1'b0, 1'b1, 2'd0, 4'hF, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 2'd0, 4'hF, 1'b0);
    cyc(1'b0, 1'b1, 2'd0, 4'hF, 1'b1);

    repeat (2) cyc(1'b0, 1'b0, 2'd1, 4'b1101, 1'b1);

    cyc(1'b0, 1'b1, 2'd0, 4'b0100, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 2'd0, 4'hF, 1'b1);
    cyc(1'b0, 1'b1, 2'd0, 4'hF, 1'b1);
    #1 chk("ptr_retained", 32'(i_ready), 32'h8);

    cyc(1'b0, 1'b1, 2'd0, 4'hF, 1'b0);
    cyc(1'b1, 1'b1, 2'd0, 4'hF, 1'b0);
    cyc(1'b0, 1'b1, 2'd0, 4'hF, 1'b1);

    @(negedge clk);
    s3 = 2'd3;
    v3 = 3'b111;
    #1 chk("n3_oor_ready", 32'(ir3), 32'h0);
    @(posedge clk);
    #1 chk("n3_oor_valid", 32'(yv3), 32'h0);
    @(negedge clk);
    s3 = 2'd2;
    #1 chk("n3_ready", 32'(ir3), 32'h4);
    @(posedge clk);
    #1;
    chk("n3_y", 32'(y3), 32'h9);
    chk("n3_y_sel", 32'(ysel3), 32'h2);
    chk("n3_y_valid", 32'(yv3), 32'h1);
    @(negedge clk);
    s3 = 2'd0;
    v3 = 3'b110;
    #1 chk("n3_inv_ready", 32'(ir3), 32'h0);
    @(posedge clk);
    #1;
    chk("n3_drain_valid", 32'(yv3), 32'h0);
    chk("n3_y_held", 32'(y3), 32'h9);
    v3 = '0;

    repeat (400)
      cyc(($urandom_range(63) == 0), 1'($urandom_range(1)),
          2'($urandom_range(3)), 4'($urandom_range(15)),
          ($urandom_range(3) != 0));

    repeat (3) cyc(1'b0, 1'b1, 2'd0, 4'h0, 1'b1);
    @(posedge clk);
    #2 chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
